spi_txn_arbiter: RTL

Shares one byte-level SPI controller between two requesters (e.g. CPU peripheral port and LCD streamer) on a per-transaction basis. A granted requester owns the bus from its first byte until a byte tagged end-of-transaction completes. Each transaction is preceded by a one-cycle reconfiguration of the controller's clock divider and read latency for the owner. Sits between the requesters and the SPI controller's start/busy interface.

---
 rtl/spi_arb_pkg.sv | 15 +
 rtl/spi_arb_pick.sv | 33 +++
 rtl/spi_txn_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the two-requester SPI transaction arbiter.
package spi_arb_pkg;
  localparam int NREQ   = 2;
  localparam int BYTE_W = 8;
  localparam int DIV_W  = 2;
  localparam logic [DIV_W-1:0] DIV_RST = 2'd1;

  typedef enum logic [2:0] {
    IDLE,
    CFG,
    ISSUE,
    SETTLE,
    RUN
  } state_t;
endpackage

// File: rtl/spi_arb_pick.sv
// Combinational owner selection, one-hot result; zero when nobody requests.
// SPI_ARB_RR_EN: a tie goes to the requester that did not own the previous transaction.
module spi_arb_pick
  import spi_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
`ifdef SPI_ARB_RR_EN
  input  logic [NREQ-1:0] last_owner,
`endif
  output logic [NREQ-1:0] pick
);

  always_comb begin
    pick = '0;
`ifdef SPI_ARB_RR_EN
    // last_owner is always one-hot, so its complement names the other requester
    if (&req) begin
      pick = ~last_owner;
    end else if (req[0]) begin
      pick = 2'b01;
    end else if (req[1]) begin
      pick = 2'b10;
    end
`else
    if (req[0]) begin
      pick = 2'b01;
    end else if (req[1]) begin
      pick = 2'b10;
    end
`endif
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Locks one SPI byte controller to a requester from first byte to its end_txn byte; ack is combinational, done one cycle after busy drops.
// A waiting owner stalls everyone; non-owner requests are ignored. SPI_ARB_RR_EN selects round-robin ties, else requester 0 wins.
module spi_txn_arbiter
  import spi_arb_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_dc,
  input  logic [NREQ-1:0]          req_end_txn,
  input  logic [NREQ*BYTE_W-1:0]   req_data,
  input  logic [NREQ*DIV_W-1:0]    cfg_divider,
  input  logic [NREQ-1:0]          cfg_read_latency,
  output logic [NREQ-1:0]          ack,
  output logic [NREQ-1:0]          done,
  output logic [BYTE_W-1:0]        rdata,
  output logic [NREQ-1:0]          grant,
  output logic                     spi_start,
  output logic                     spi_dc,
  output logic                     spi_end_txn,
  output logic [BYTE_W-1:0]        spi_data,
  output logic                     spi_set_config,
  output logic [DIV_W-1:0]         spi_divider,
  output logic                     spi_read_latency,
  input  logic                     spi_busy,
  input  logic [BYTE_W-1:0]        spi_data_out
);

  state_t          state, state_nxt;
  logic [NREQ-1:0] pick;
  logic            owner;
  logic            issue;
  logic            run_fin;
  logic            end_q;
`ifdef SPI_ARB_RR_EN
  logic [NREQ-1:0] last_owner;
`endif

  spi_arb_pick u_pick (
    .req        (req),
`ifdef SPI_ARB_RR_EN
    .last_owner (last_owner),
`endif
    .pick       (pick)
  );

  assign owner   = grant[1];
  assign issue   = (state == ISSUE) && req[owner] && !spi_busy;
  assign run_fin = (state == RUN) && !spi_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = CFG;
      CFG:     state_nxt = ISSUE;
      ISSUE:   if (issue) state_nxt = SETTLE;
      SETTLE:  state_nxt = RUN;
      RUN:     if (run_fin) state_nxt = end_q ? IDLE : ISSUE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    spi_set_config = (state == CFG);
    spi_start      = issue;
    ack            = issue ? grant : '0;
    spi_dc         = issue & req_dc[owner];
    spi_end_txn    = issue & req_end_txn[owner];
    spi_data       = '0;
    if (issue) begin
      spi_data = owner ? req_data[2*BYTE_W-1:BYTE_W] : req_data[BYTE_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant            <= '0;
      end_q            <= 1'b0;
      done             <= '0;
      rdata            <= '0;
      spi_divider      <= DIV_RST;
      spi_read_latency <= 1'b0;
`ifdef SPI_ARB_RR_EN
      last_owner       <= 2'b01;
`endif
    end else begin
      done <= '0;
      // owner's config is loaded with the grant so it is stable during CFG
      if (state == IDLE && |req) begin
        grant            <= pick;
        spi_divider      <= pick[1] ? cfg_divider[2*DIV_W-1:DIV_W] : cfg_divider[DIV_W-1:0];
        spi_read_latency <= pick[1] ? cfg_read_latency[1] : cfg_read_latency[0];
      end
      if (issue) begin
        end_q <= req_end_txn[owner];
      end
      if (run_fin) begin
        done  <= grant;
        rdata <= spi_data_out;
        if (end_q) begin
          grant <= '0;
`ifdef SPI_ARB_RR_EN
          last_owner <= grant;
`endif
        end
      end
    end
  end

endmodule
